// File: rtl/add_arbiter_pkg.sv
// add_arb_pkg: shared defaults and state encoding for the round-robin adder arbiter
package add_arb_pkg;
  localparam int ARB_NREQ = 4;
  localparam int ARB_WIDTH = 32;
  localparam int ARB_ID_W = $clog2(ARB_NREQ);
  typedef enum logic {EMPTY, FULL} arb_state_e;
endpackage

// File: rtl/add_arbiter_rca.sv
// RippleCarryAdder: WIDTH-bit ripple-carry adder
//   a, b : operands      cin  : carry-in
//   sum  : a+b+cin       cout : carry out of the MSB
module RippleCarryAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbitration of NREQ requesters onto one registered adder
//   req_valid/req_ready : per-requester handshake, one grant per accepting cycle
//   req_A/req_B/req_Cin : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : result handshake; rsp_id, Sum, Cout, Ovf are registered
module add_arbiter import add_arb_pkg::*; #(
  parameter  int NREQ  = ARB_NREQ,
  parameter  int WIDTH = ARB_WIDTH,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_A,
  input  logic [NREQ*WIDTH-1:0] req_B,
  input  logic [NREQ-1:0]       req_Cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      Sum,
  output logic                  Cout,
  output logic                  Ovf
);
  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [ID_W-1:0]  grant;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] a_mux, b_mux;
  logic             cin_mux;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  // first valid requester at or after ptr, wrapping around
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end
  assign a_mux   = req_A[int'(grant)*WIDTH +: WIDTH];
  assign b_mux   = req_B[int'(grant)*WIDTH +: WIDTH];
  assign cin_mux = req_Cin[grant];
  RippleCarryAdder #(.WIDTH(WIDTH)) u_add (
    .a    (a_mux),
    .b    (b_mux),
    .cin  (cin_mux),
    .sum  (add_sum),
    .cout (add_cout)
  );
  assign add_ovf = (a_mux[WIDTH-1] == b_mux[WIDTH-1]) && (add_sum[WIDTH-1] != a_mux[WIDTH-1]);
  // a held result frees its slot in the same cycle it is consumed
  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign accept     = can_accept && found && !rst;
  assign req_ready  = accept ? (NREQ'(1) << grant) : '0;
  always_comb begin
    state_d = accept ? FULL : ((state_q == FULL) && rsp_ready) ? EMPTY : state_q;
    ptr_d   = accept ? ID_W'((int'(grant) + 1) % NREQ) : ptr_q;
    id_d    = accept ? grant : id_q;
    sum_d   = accept ? add_sum : sum_q;
    cout_d  = accept ? add_cout : cout_q;
    ovf_d   = accept ? add_ovf : ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter
module tb_add_arbiter;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  logic [3:0][31:0] a_v = '0;
  logic [3:0][31:0] b_v = '0;
  logic [3:0]       cin_v = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_id;
  logic [31:0]      Sum;
  logic             Cout;
  logic             Ovf;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_sum [4] = '{32'd103, 32'd205, 32'd305, 32'd407};

  add_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (a_v),
    .req_B     (b_v),
    .req_Cin   (cin_v),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      a_v[i]   = 32'(100 * (i + 1));
      b_v[i]   = 32'(i + 3);
      cin_v[i] = 1'(i & 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    step();
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (Sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %h exp 0", Sum); end
    checks++; if ({Cout, Ovf, rsp_id} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {Cout, Ovf, rsp_id}); end
    req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    a_v[0] = 32'd5;
    b_v[0] = 32'd7;
    cin_v[0] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    checks++; if (Sum !== 32'd13) begin errors++; $display("FAIL single_sum got %0d exp 13", Sum); end
    checks++; if ({Cout, rsp_id} !== 3'b000) begin errors++; $display("FAIL single_cout_id got %b exp 000", {Cout, rsp_id}); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready got %b exp 0000", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", rsp_valid); end
    checks++; if (Sum !== 32'd13) begin errors++; $display("FAIL drain_hold_sum got %0d exp 13", Sum); end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    load_ops();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << g)); end
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, rsp_valid); end
      checks++; if (rsp_id !== 2'(g)) begin errors++; $display("FAIL b2b_id[%0d] got %0d exp %0d", k, rsp_id, g); end
      checks++; if (Sum !== exp_sum[g]) begin errors++; $display("FAIL b2b_sum[%0d] got %0d exp %0d", k, Sum, exp_sum[g]); end
    end
    req_valid = '0;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_boundary();
    a_v[2] = 32'hFFFF_FFFF;
    b_v[2] = 32'h0000_0001;
    cin_v[2] = 1'b0;
    a_v[3] = 32'h7FFF_FFFF;
    b_v[3] = 32'h0000_0001;
    cin_v[3] = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ready got %b exp 0100", req_ready); end
    step();
    req_valid = 4'b1000;
    #1;
    checks++; if (Sum !== 32'h0) begin errors++; $display("FAIL wrap_sum got %h exp 00000000", Sum); end
    checks++; if ({Cout, Ovf, rsp_id} !== 4'b1010) begin errors++; $display("FAIL wrap_flags got %b exp 1010", {Cout, Ovf, rsp_id}); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ovf_ready got %b exp 1000", req_ready); end
    step();
    req_valid = '0;
    checks++; if (Sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum got %h exp 80000000", Sum); end
    checks++; if ({Cout, Ovf, rsp_id} !== 4'b0111) begin errors++; $display("FAIL ovf_flags got %b exp 0111", {Cout, Ovf, rsp_id}); end
    step();
  endtask

  task automatic test_stall();
    load_ops();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0000", k, req_ready); end
      checks++; if ({rsp_valid, rsp_id, Sum} !== {1'b1, 2'd0, 32'd103}) begin errors++; $display("FAIL stall_hold[%0d] got %b/%0d/%0d exp 1/0/103", k, rsp_valid, rsp_id, Sum); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL release_ready got %b exp 0010", req_ready); end
    step();
    checks++; if ({rsp_valid, rsp_id, Sum} !== {1'b1, 2'd1, 32'd205}) begin errors++; $display("FAIL release_rsp got %b/%0d/%0d exp 1/1/205", rsp_valid, rsp_id, Sum); end
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL arst_ready got %b exp 0000", req_ready); end
    checks++; if (Sum !== 32'd0) begin errors++; $display("FAIL arst_sum got %0d exp 0", Sum); end
    step();
    rst = 1'b0;
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL post_rst_ready got %b exp 0010", req_ready); end
    step();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, Sum} !== {1'b1, 2'd1, 32'd205}) begin errors++; $display("FAIL post_rst_rsp got %b/%0d/%0d exp 1/1/205", rsp_valid, rsp_id, Sum); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary();
    test_stall();
    test_async_reset();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the adder.
REQ-002 SHALL have parameter WIDTH, default 32, operand/sum width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  bit i: requester i presents an operation.
REQ-006 SHALL have port req_ready  output  NREQ  bit i: operation of requester i accepted this cycle.
REQ-007 SHALL have port req_A  input  NREQ*WIDTH  packed operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_B  input  NREQ*WIDTH  packed operand B, same packing.
REQ-009 SHALL have port req_Cin  input  NREQ  carry-in per requester.
REQ-010 SHALL have port rsp_valid  output  1  result register holds a result.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port rsp_id  output  clog2(NREQ)  index of requester owning the result.
REQ-013 SHALL have port Sum  output  WIDTH  registered sum.
REQ-014 SHALL have port Cout  output  1  registered carry-out of MSB.
REQ-015 SHALL have port Ovf  output  1  registered signed overflow.

Function
REQ-016 SHALL implement FSM with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 SHALL define can_accept = (state==EMPTY) or (rsp_valid and rsp_ready).
REQ-018 SHALL, when can_accept and any req_valid, assert exactly one req_ready bit: the first valid index searching upward (with wrap) from ptr.
REQ-019 SHALL keep req_ready all-zero when can_accept=0 or no req_valid; req_ready SHALL never be set for a requester whose req_valid=0.
REQ-020 SHALL on an accepting edge load Sum/Cout = A+B+Cin (mod 2^WIDTH, carry to Cout) of the granted requester, rsp_id = grant index, go/stay FULL; latency 1 cycle from acceptance to rsp_valid.
REQ-021 SHALL compute Ovf = (A[MSB]==B[MSB]) and (Sum[MSB]!=A[MSB]).
REQ-022 SHALL on drain without new acceptance (FULL, rsp_ready=1, no req_valid) go EMPTY; Sum/Cout/Ovf/rsp_id hold last values.
REQ-023 SHALL support simultaneous drain and accept in one cycle (back-to-back, one result per cycle sustained).
REQ-024 SHALL hold Sum/Cout/Ovf/rsp_id stable while FULL and rsp_ready=0.
REQ-025 SHALL update ptr to (grant+1) mod NREQ only on accepting edges; otherwise ptr holds.
REQ-026 SHALL guarantee a requester holding req_valid is granted within NREQ accepted transfers (round-robin fairness).
REQ-027 SHALL treat req_valid as sampled each cycle; deasserting before grant drops the request without side effect.

Reset
REQ-028 SHALL on rst=1, asynchronously: state=EMPTY, rsp_valid=0, Sum=0, Cout=0, Ovf=0, rsp_id=0, ptr=0 (requester 0 highest priority first).
REQ-029 SHALL drop any in-flight result on reset mid-operation; req_ready SHALL be all-zero while rst=1.

Structure
REQ-030 SHALL place NREQ, WIDTH, ID_W=clog2(NREQ) defaults and the state enum (EMPTY, FULL) in shared package add_arb_pkg.
REQ-031 SHALL instantiate exactly one adder sub-module, the team's existing RippleCarryAdder, fed by a grant-indexed operand mux.
REQ-032 SHALL keep the round-robin priority encoder inside add_arbiter, combinational, no extra sub-module.

Verification
REQ-033 Reset then req_valid=0001, A0=5, B0=7, Cin0=1, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, Sum=13, Cout=0, rsp_id=0.
REQ-034 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one rsp per cycle, rsp_id sequence matches.
REQ-035 A=FFFFFFFF, B=00000001, Cin=0 -> Sum=0, Cout=1, Ovf=0; A=7FFFFFFF, B=1 -> Sum=80000000, Cout=0, Ovf=1.
REQ-036 Result FULL, rsp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000, outputs stable; rsp_ready=1 -> drain and new grant same cycle.
REQ-037 rst asserted mid-stream while FULL -> rsp_valid=0 immediately (asynchronous), after release first grant goes to lowest valid index from 0.
